// File: rtl/xm_mem_responder.sv
// xm_mem_responder: memory-side responder for the XMakina core's memory handshake.
// Each accepted request holds memBusy_o for WAIT_STATES+1 cycles. The access then
// completes as a word or byte read or write on a little-endian, byte-addressed array.
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic            memBusy_o,
  output logic            done_o,
  output logic            err_o
);

  // Width of the storage index actually used to address the array.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth expressed at the width of the word-index field, for the range check.
  localparam logic [WORD-2:0] DEPTH_IDX = (WORD-1)'(DEPTH);

  // Value loaded into the wait counter on accept.
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic       complete;

  // Request registers: captured on accept, so the requester may drop its inputs early.
  logic            req_rw;
  logic            req_byte;
  logic [WORD-1:0] req_adr;
  logic [WORD-1:0] req_wdata;

  // Storage array. Reset does not clear it.
  logic [WORD-1:0] mem [DEPTH];

  logic [AW-1:0]   mem_idx;
  logic [WORD-1:0] mem_word;
  logic            misaligned;
  logic            out_of_range;
  logic            fault;
  logic [WORD-1:0] rd_word;
  logic [WORD-1:0] wr_word;

  logic [WORD-1:0] rdata_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  assign mem_idx      = req_adr[AW:1];
  assign mem_word     = mem[mem_idx];
  assign misaligned   = !req_byte && req_adr[0];
  assign out_of_range = (req_adr[WORD-1:1] >= DEPTH_IDX);
  assign fault        = misaligned || out_of_range;

  assign rdata_o   = rdata_q;
  assign memBusy_o = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  // Next-state logic: accept a request in IDLE, then count down the wait states in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memEn_i) begin
          accept    = 1'b1;
          cnt_nxt   = WS_INIT;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Read path: select the whole word, or one zero-extended lane. A faulted access reads as zero.
  always_comb begin
    rd_word = '0;
    if (!fault) begin
      if (req_byte) begin
        rd_word[7:0] = req_adr[0] ? mem_word[15:8] : mem_word[7:0];
      end else begin
        rd_word = mem_word;
      end
    end
  end

  // Write path: a byte write merges into the existing word, so the other lane survives.
  always_comb begin
    wr_word = mem_word;
    if (req_byte) begin
      if (req_adr[0]) begin
        wr_word[15:8] = req_wdata[7:0];
      end else begin
        wr_word[7:0] = req_wdata[7:0];
      end
    end else begin
      wr_word = req_wdata;
    end
  end

  // Control and output registers. Reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt == ST_WAIT);
      done_q <= complete;
      err_q  <= complete && fault;
      if (complete && !req_rw) begin
        rdata_q <= rd_word;
      end
    end
  end

  // Capture the request on the accept edge. Inputs during WAIT are ignored.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_rw    <= memRW_i;
      req_byte  <= byteOp_i;
      req_adr   <= adr_i;
      req_wdata <= wdata_i;
    end
  end

  // Array write at the completion edge, suppressed on a fault or under reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && complete && req_rw && !fault) begin
      mem[mem_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_xm_mem_responder.sv
// tb_xm_mem_responder: directed and randomized bench for xm_mem_responder.
// A transaction-level model predicts every output on every cycle.
module tb_xm_mem_responder;

  localparam int WORD  = 16;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;

  logic            clk;
  logic            rst;
  logic            mem_en;
  logic            mem_rw;
  logic            byte_op;
  logic [WORD-1:0] adr;
  logic [WORD-1:0] wdata;
  logic [WORD-1:0] rdata;
  logic            mem_busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  xm_mem_responder #(
    .WORD(WORD),
    .DEPTH(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .memEn_i(mem_en),
    .memRW_i(mem_rw),
    .byteOp_i(byte_op),
    .adr_i(adr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .memBusy_o(mem_busy),
    .done_o(done),
    .err_o(err)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: outputs, one pending request with its due cycle, and a shadow array.
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_rdata = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic        model_valid = 1'b0;
  logic        pend = 1'b0;
  int          cyc = 0;
  int          due = 0;
  logic        p_rw;
  logic        p_byte;
  logic [15:0] p_adr;
  logic [15:0] p_wdata;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: a request is accepted when idle and completes WS+1 edges later.
  always @(posedge clk) begin
    int idx;
    logic bad;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_rdata = '0;
      pend = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      m_err = 1'b0;
      if (pend && cyc == due) begin
        idx = int'(p_adr >> 1);
        bad = (!p_byte && p_adr[0]) || (idx >= DEPTH);
        m_done = 1'b1;
        m_busy = 1'b0;
        pend = 1'b0;
        if (bad) begin
          m_err = 1'b1;
          if (!p_rw) m_rdata = '0;
        end else if (!p_rw) begin
          if (!p_byte) m_rdata = m_mem[idx];
          else if (p_adr[0]) m_rdata = {8'h00, m_mem[idx][15:8]};
          else m_rdata = {8'h00, m_mem[idx][7:0]};
        end else begin
          if (!p_byte) m_mem[idx] = p_wdata;
          else if (p_adr[0]) m_mem[idx][15:8] = p_wdata[7:0];
          else m_mem[idx][7:0] = p_wdata[7:0];
        end
      end else if (!pend && mem_en) begin
        pend = 1'b1;
        due = cyc + WS + 1;
        p_rw = mem_rw;
        p_byte = byte_op;
        p_adr = adr;
        p_wdata = wdata;
        m_busy = 1'b1;
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("busy", {15'b0, mem_busy}, {15'b0, m_busy});
      checkOutput("done", {15'b0, done}, {15'b0, m_done});
      checkOutput("err", {15'b0, err}, {15'b0, m_err});
      checkOutput("rdata", rdata, m_rdata);
    end
  end

  // One access: pulse memEn_i for one cycle, then wait (bounded) for done_o.
  task automatic applyStimulus(input logic rw, input logic bop, input logic [15:0] a,
                               input logic [15:0] wd, output int busy_cycles,
                               output logic got_done, output logic got_err,
                               output logic [15:0] got_rdata);
    @(negedge clk);
    mem_en = 1'b1;
    mem_rw = rw;
    byte_op = bop;
    adr = a;
    wdata = wd;
    busy_cycles = 0;
    got_done = 1'b0;
    got_err = 1'b0;
    got_rdata = '0;
    for (int n = 0; n < 40 && !got_done; n++) begin
      @(negedge clk);
      mem_en = 1'b0;
      if (mem_busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        got_err = err;
        got_rdata = rdata;
      end
    end
    if (!got_done) checkOutput("done_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    int bc;
    logic gd;
    logic ge;
    logic [15:0] gr;
    int n_done;
    int stamps [4];
    int r;
    logic [14:0] ridx;

    rst = 1'b1;
    mem_en = 1'b0;
    mem_rw = 1'b0;
    byte_op = 1'b0;
    adr = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {15'b0, mem_busy}, 16'd0);
    checkOutput("reset_done", {15'b0, done}, 16'd0);
    checkOutput("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;

    // Preload words 0..15 through the write port.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = 16'h1000 + 16'(i) * 16'h0101;
      if (i == 2) v = 16'hC0DE;
      if (i == 3) v = 16'hBEEF;
      applyStimulus(1'b1, 1'b0, 16'(i * 2), v, bc, gd, ge, gr);
    end

    // Word read of mem[3]: three busy cycles, then BEEF.
    applyStimulus(1'b0, 1'b0, 16'd6, 16'h0, bc, gd, ge, gr);
    checkOutput("rd6_busy_cycles", 16'(bc), 16'd3);
    checkOutput("rd6_done", {15'b0, gd}, 16'd1);
    checkOutput("rd6_err", {15'b0, ge}, 16'd0);
    checkOutput("rd6_data", gr, 16'hBEEF);

    // Byte write to the high lane, then word and byte reads.
    applyStimulus(1'b1, 1'b1, 16'd7, 16'hFF5A, bc, gd, ge, gr);
    applyStimulus(1'b0, 1'b0, 16'd6, 16'h0, bc, gd, ge, gr);
    checkOutput("after_bw_word", gr, 16'h5AEF);
    applyStimulus(1'b0, 1'b1, 16'd6, 16'h0, bc, gd, ge, gr);
    checkOutput("byte_rd_lo", gr, 16'h00EF);
    applyStimulus(1'b0, 1'b1, 16'd7, 16'h0, bc, gd, ge, gr);
    checkOutput("byte_rd_hi", gr, 16'h005A);

    // Misaligned word read and write.
    applyStimulus(1'b0, 1'b0, 16'd5, 16'h0, bc, gd, ge, gr);
    checkOutput("misalign_err", {15'b0, ge}, 16'd1);
    checkOutput("misalign_rdata", gr, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'd5, 16'hDEAD, bc, gd, ge, gr);
    checkOutput("misalign_wr_err", {15'b0, ge}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'd4, 16'h0, bc, gd, ge, gr);
    checkOutput("mem2_kept", gr, 16'hC0DE);

    // Out-of-range read and write; the write must not alias onto mem[0].
    applyStimulus(1'b0, 1'b0, 16'(2 * DEPTH), 16'h0, bc, gd, ge, gr);
    checkOutput("oor_rd_err", {15'b0, ge}, 16'd1);
    checkOutput("oor_rd_data", gr, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'(2 * DEPTH), 16'hFACE, bc, gd, ge, gr);
    checkOutput("oor_wr_err", {15'b0, ge}, 16'd1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'h0, bc, gd, ge, gr);
    checkOutput("mem0_kept", gr, 16'h1000);

    // A second pulse during busy is ignored.
    @(negedge clk);
    mem_en = 1'b1; mem_rw = 1'b0; byte_op = 1'b0; adr = 16'd6;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mem_en = (k == 1);
      if (done) n_done++;
    end
    checkOutput("ignored_pulse_dones", 16'(n_done), 16'd1);

    // memEn_i held high: back-to-back reads complete WS+2 cycles apart.
    @(negedge clk);
    mem_en = 1'b1; adr = 16'd6;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done && n_done < 4) begin
        stamps[n_done] = k;
        n_done++;
      end
    end
    mem_en = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("b2b_count", 16'(n_done), 16'd2);
    checkOutput("b2b_gap", 16'(stamps[1] - stamps[0]), 16'(WS + 2));

    // Reset during a write abandons it.
    @(negedge clk);
    mem_en = 1'b1; mem_rw = 1'b1; byte_op = 1'b0; adr = 16'd6; wdata = 16'h1234;
    @(negedge clk);
    mem_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {15'b0, mem_busy}, 16'd0);
    checkOutput("midrst_rdata", rdata, 16'h0000);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'd6, 16'h0, bc, gd, ge, gr);
    checkOutput("midrst_mem3", gr, 16'h5AEF);

    // Randomized traffic over the preloaded window plus out-of-range addresses.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 8) ridx = 15'($urandom_range(0, 15));
      else if (r == 8) ridx = 15'(DEPTH + $urandom_range(0, 3));
      else ridx = 15'h7FFF;
      mem_en = ($urandom_range(0, 2) == 0);
      mem_rw = 1'($urandom_range(0, 1));
      byte_op = 1'($urandom_range(0, 1));
      adr = {ridx, 1'($urandom_range(0, 1))};
      wdata = 16'($urandom);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    mem_en = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xm_mem_responder.md
# xm_mem_responder

Memory-side responder for the XMakina multi-cycle core's memory handshake. Accepts one access per request pulse on `memEn_i`, holds `memBusy_o` for a configurable number of wait states, then performs a word or byte read/write on an internal little-endian, byte-addressed word array. It sits between the controller/datapath and the instruction/data store, and is the unit that drives the controller's `memBusy_i`.

## Interface
- `WORD`, 16, data and address width in bits.
- `DEPTH`, 1024, number of WORD-wide storage words.
- `WAIT_STATES`, 2, extra busy cycles per access (0..15).
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `memEn_i`  in  1  access request; sampled only in IDLE.
- `memRW_i`  in  1  0 = read, 1 = write.
- `byteOp_i`  in  1  1 = byte access, 0 = word access.
- `adr_i`  in  WORD  byte address; word index is `adr_i[WORD-1:1]`, byte lane is `adr_i[0]`.
- `wdata_i`  in  WORD  write data; only `[7:0]` is used for byte writes.
- `rdata_o`  out  WORD  read data, registered.
- `memBusy_o`  out  1  access in progress.
- `done_o`  out  1  one-cycle pulse when an access completes.
- `err_o`  out  1  one-cycle pulse coincident with `done_o` for a faulted access.

## Operation
- States: IDLE and WAIT. A 4-bit wait counter `cnt` runs in WAIT.
- IDLE, `memEn_i`=1 at an edge:
  - capture `memRW_i`, `byteOp_i`, `adr_i`, `wdata_i` into request registers;
  - load `cnt` with WAIT_STATES;
  - set `memBusy_o`=1 and go to WAIT.
- IDLE, `memEn_i`=0: no change.
- WAIT, `cnt`≠0: decrement `cnt`. Inputs are ignored, including `memEn_i`, and requests are not queued.
- WAIT, `cnt`=0, completion edge:
  - perform the access using the captured request;
  - set `memBusy_o`=0 and pulse `done_o`=1;
  - go to IDLE.
- Word read: `rdata_o` = mem[idx].
- Byte read: `rdata_o` = {8'h00, lane}. The lane is mem[idx][7:0] if `adr[0]`=0, otherwise mem[idx][15:8]. Zero-extended.
- Word write: mem[idx] = wdata. `rdata_o` is unchanged.
- Byte write: only the selected lane is replaced with `wdata[7:0]`. The other lane is preserved. `rdata_o` is unchanged.
- Faults, with `err_o` pulsed together with `done_o`:
  - a word access with `adr[0]`=1 (misaligned);
  - idx ≥ DEPTH (out of range).
- On a fault, no array write occurs, and a faulted read loads `rdata_o`=0.
- The array is not cleared by reset. Initial contents are undefined unless preloaded by the bench.

## Timing
- Reset values: state IDLE, `cnt`=0, `memBusy_o`=0, `done_o`=0, `err_o`=0, `rdata_o`=0.
- Reset in the middle of an access abandons it. No array write occurs, and all outputs return to their reset values on the next edge.
- Accept edge E0. `memBusy_o` is high from E0 through E0+WAIT_STATES. The completion edge is E0+WAIT_STATES+1. This gives WAIT_STATES+1 busy cycles.
- With WAIT_STATES=0, busy lasts exactly one cycle.
- At the completion edge `memBusy_o` falls. In that same cycle `done_o` and `err_o` are valid and `rdata_o` holds the new read data.
- `rdata_o` holds until the next completing read or a reset.
- Back-to-back accesses: a request sampled at the first edge after completion is accepted, so the minimum request period is WAIT_STATES+2 cycles.
- The requester samples `memBusy_o` no earlier than the cycle after its `memEn_i` pulse. It may deassert `memEn_i` after one cycle because the request is captured at E0.
- `memEn_i` held high continuously issues a new access every WAIT_STATES+2 cycles.

## Test plan
- Reset, then preload mem[3]=16'hBEEF. Word read at `adr_i`=6 with WAIT_STATES=2 gives: `memBusy_o` high for exactly 3 cycles, then `rdata_o`=16'hBEEF with a one-cycle `done_o` and `err_o`=0.
- Byte write of 8'h5A to `adr_i`=7, then a word read at 6 gives 16'h5AEF. A byte read at 6 gives 16'h00EF.
- Word read at `adr_i`=5 (misaligned) gives `err_o`=1 with `done_o` and `rdata_o`=0. A word write at 5 leaves mem[2] unchanged.
- `adr_i`=2*DEPTH gives `err_o`=1, no write, and a read result of 0.
- `memEn_i` pulsed again during busy is ignored: exactly one `done_o` occurs. With `memEn_i` held high, two back-to-back reads complete WAIT_STATES+2 cycles apart.
- Write of 16'h1234 to mem[3] is started, and `rst_i` is asserted at cycle 1 of WAIT. Outputs return to their reset values and a subsequent read of mem[3] still returns 16'h5AEF.
